instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
//
// Fetches one 32-bit word at a time from instruction memory, holds it for
// decode until consumed, then computes the next pc from the branch inputs
// (PCsrc/ImmOp) or from the external redirect (flush/flush_pc).
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   imem_req/imem_addr  fetch request and word-aligned address
//   imem_gnt            memory accepted the request this cycle
//   imem_rvalid/rdata   read response
//   instr/instr_pc      instruction and its address presented to decode
//   instr_valid         instr/instr_pc are valid
//   instr_ready         decode consumes instr this cycle
//   PCsrc/ImmOp         taken-branch select and offset, sampled on accept
//   flush/flush_pc      external redirect, highest priority
//   misalign            one-cycle pulse when a redirect target was not word aligned
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCsrc,
    input  logic [31:0] ImmOp,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        misalign
);

    typedef enum logic [1:0] {
        StFetch,  // request driven, waiting for grant
        StWait,   // one request outstanding
        StFull,   // instruction held for decode
        StDrop    // discard the one in-flight response
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        misalign_q, misalign_d;
    logic        run_q;

    logic        req_active;
    logic        accept;
    logic        load_pc;
    logic [31:0] target;

    // run_q keeps imem_req low between reset release and the first clock edge.
    assign req_active = (state_q == StFetch) && run_q;
    assign accept     = (state_q == StFull) && instr_ready;
    assign load_pc    = flush || accept;

    // Redirect target; flush wins over the branch decision.
    always_comb begin
        target = instr_pc_q + 32'd4;
        if (flush) begin
            target = flush_pc;
        end else if (PCsrc) begin
            target = instr_pc_q + ImmOp;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = 1'b0;

        if (load_pc) begin
            pc_d       = {target[31:2], 2'b00};
            misalign_d = |target[1:0];
        end

        if (flush) begin
            unique case (state_q)
                // A request granted in the flush cycle is still in flight.
                StFetch: state_d = (req_active && imem_gnt) ? StDrop : StFetch;
                StWait:  state_d = imem_rvalid ? StFetch : StDrop;
                StFull:  state_d = StFetch;
                // A response arriving with the flush retires the in-flight request.
                StDrop:  state_d = imem_rvalid ? StFetch : StDrop;
                default: state_d = StFetch;
            endcase
        end else begin
            unique case (state_q)
                StFetch: begin
                    // Any rvalid here belongs to nothing and is ignored.
                    if (req_active && imem_gnt) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        state_d    = StFull;
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                    end
                end
                StFull: begin
                    if (instr_ready) begin
                        state_d = StFetch;
                    end
                end
                StDrop: begin
                    if (imem_rvalid) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            misalign_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
            run_q      <= 1'b1;
        end
    end

    assign imem_req    = req_active;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == StFull);
    assign misalign    = misalign_q;

endmodule
